prog_clk_div: RTL and testbench

Runtime-programmable integer clock divider: the parametrised successor of the fixed even-ratio divider in the clock chain. Produces a 50 %-duty `o_clk` for any even or odd ratio N ≥ 2 and a one-cycle `o_tick` strobe per output period. Supports clean start/stop and glitch-free ratio changes applied only at period boundaries. Feeds the seconds/minutes timebase and display-scan logic.

---
 rtl/clk_div_pkg.sv | 29 ++
 rtl/prog_clk_div_if.sv | 23 ++
 rtl/negedge_retime.sv | 19 +
 rtl/prog_clk_div.sv | 141 ++++++++++++++
 tb/tb_prog_clk_div.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: minimum ratio,
// FSM encoding and the divisor arithmetic helpers. The helpers work on a
// 32-bit value, so users must keep their divisor width at 32 bits or less.
package clk_div_pkg;

  localparam logic [31:0] MIN_DIV = 32'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Ratios below MIN_DIV cannot make a two-phase clock, so raise them.
  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    logic [31:0] r;
    if (n < MIN_DIV) begin
      r = MIN_DIV;
    end else begin
      r = n;
    end
    return r;
  endfunction

  // H(N) = ceil(N/2), written so that it cannot overflow at the top of the range.
  function automatic logic [31:0] half_period(input logic [31:0] n);
    return (n >> 5'd1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/prog_clk_div_if.sv
// Control/status bundle of the programmable clock divider.
interface prog_clk_div_if #(
  parameter int unsigned WIDTH = 26
) ();

  logic             i_en;
  logic [WIDTH-1:0] i_div;
  logic             i_load;
  logic             o_clk;
  logic             o_tick;
  logic             o_pending;

  modport master (
    output i_en, i_div, i_load,
    input  o_clk, o_tick, o_pending
  );

  modport slave (
    input  i_en, i_div, i_load,
    output o_clk, o_tick, o_pending
  );

endinterface

// File: rtl/negedge_retime.sv
// Single falling-edge flop. Kept in its own module so the dual-edge path of
// the divider can be constrained separately.
module negedge_retime (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  // Capture the phase flop on the falling edge; cleared at once by reset.
  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_q <= 1'b0;
    end else begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/prog_clk_div.sv
// Runtime-programmable integer clock divider. 50 % duty for any ratio N >= 2,
// one o_tick per output period, start/stop and ratio changes only at period
// boundaries so the output never glitches.
module prog_clk_div
  import clk_div_pkg::*;
#(
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned DEFAULT_DIV = 50000000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  prog_clk_div_if.slave bus
);

  localparam logic [31:0]      DEF_FULL = clamp_div(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] DEF_DIV  = DEF_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             p_q, p_d;
  logic             tick_q, tick_d;
  logic             n_q;

  logic [31:0]      div_in_ext;
  logic [31:0]      load_clamped;
  logic [31:0]      act_next_ext;
  logic [31:0]      half_ext;
  logic             unused_ext;

  // Widen the incoming divisor and clamp it for the pending register.
  always_comb begin
    div_in_ext             = 32'd0;
    div_in_ext[WIDTH-1:0]  = bus.i_div;
    load_clamped           = clamp_div(div_in_ext);
  end

  // Sequencing: IDLE/RUN, period counter, divisor hand-over at boundaries.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = ZERO;
        if (bus.i_en) begin
          if (pend_q) begin
            div_act_d = div_pend_q;
            pend_d    = 1'b0;
          end else begin
            div_act_d = div_act_q;
          end
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_q == (div_act_q - ONE)) begin
          if (pend_q) begin
            div_act_d = div_pend_q;
            pend_d    = 1'b0;
          end else begin
            div_act_d = div_act_q;
          end
          cnt_d = ZERO;
          if (bus.i_en) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = ZERO;
      end
    endcase
    // A load in the boundary cycle lands after the hand-over, so it stays pending.
    if (bus.i_load) begin
      div_pend_d = load_clamped[WIDTH-1:0];
      pend_d     = 1'b1;
    end else begin
      div_pend_d = div_pend_q;
    end
  end

  // Phase and tick are decoded from the next state so both come out of flops.
  always_comb begin
    act_next_ext            = 32'd0;
    act_next_ext[WIDTH-1:0] = div_act_d;
    half_ext                = half_period(act_next_ext);
    p_d    = (state_d == ST_RUN) && (cnt_d < half_ext[WIDTH-1:0]);
    tick_d = (state_d == ST_RUN) && (cnt_d == (div_act_d - ONE));
  end

  assign unused_ext = ^{load_clamped, half_ext};

  // Positive-edge state register with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= ZERO;
      div_act_q  <= DEF_DIV;
      div_pend_q <= DEF_DIV;
      pend_q     <= 1'b0;
      p_q        <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      p_q        <= p_d;
      tick_q     <= tick_d;
    end
  end

  negedge_retime u_retime (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (p_q),
    .o_q   (n_q)
  );

  // Odd ratios AND in the half-cycle-late copy to shave the high time to N/2.
  // div_act_q only changes at a boundary, where o_clk is already low.
  assign bus.o_clk     = div_act_q[0] ? (p_q & n_q) : p_q;
  assign bus.o_tick    = tick_q;
  assign bus.o_pending = pend_q;

endmodule

// File: tb/tb_prog_clk_div.sv
// Bench for prog_clk_div: directed scenarios plus random traffic, compared
// every half cycle against a period-level reference model.
module tb_prog_clk_div;

  localparam int unsigned W   = 26;
  localparam int unsigned DEF = 4;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;

  prog_clk_div_if #(.WIDTH(W)) bus ();

  prog_clk_div #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: running flag, ratio of the current period, position
  // within it, and the pending ratio.
  bit          m_run;
  int unsigned m_n;
  int unsigned m_pos;
  bit          m_pv;
  int unsigned m_pend;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned clamp_m(input int unsigned d);
    return (d < 2) ? 2 : d;
  endfunction

  // Output is high for N half-cycle slots of the period: slots 0..N-1 for
  // even N, slots 1..N for odd N (it rises on a falling edge).
  function automatic bit exp_clk(input int unsigned slot);
    if (!m_run) return 1'b0;
    if ((m_n % 2) == 0) return slot < m_n;
    return (slot >= 1) && (slot <= m_n);
  endfunction

  task automatic model_reset();
    m_run  = 1'b0;
    m_n    = DEF;
    m_pos  = 0;
    m_pv   = 1'b0;
    m_pend = 0;
  endtask

  task automatic model_apply();
    if (m_pv) begin
      m_n  = m_pend;
      m_pv = 1'b0;
    end
  endtask

  // What the next rising edge does, given the inputs presented to it.
  task automatic model_edge(input bit en, input bit ld, input int unsigned dv);
    if (i_rst == 1'b0) return;
    if (!m_run) begin
      if (en) begin
        model_apply();
        m_run = 1'b1;
        m_pos = 0;
      end
    end else if (m_pos == m_n - 1) begin
      model_apply();
      m_pos = 0;
      if (!en) m_run = 1'b0;
    end else begin
      m_pos++;
    end
    if (ld) begin
      m_pend = clamp_m(dv);
      m_pv   = 1'b1;
    end
  endtask

  // One source-clock cycle: drive at falling edge + 1, check both halves.
  task automatic cycle(input bit en, input bit ld, input int unsigned dv);
    bus.i_en   = en;
    bus.i_load = ld;
    bus.i_div  = dv[W-1:0];
    model_edge(en, ld, dv);
    @(posedge i_clk);
    #1;
    check_eq("tick", {31'd0, bus.o_tick}, {31'd0, (m_run && (m_pos == m_n - 1))});
    check_eq("pending", {31'd0, bus.o_pending}, {31'd0, m_pv});
    check_eq("clk_first_half", {31'd0, bus.o_clk}, {31'd0, exp_clk(2 * m_pos)});
    @(negedge i_clk);
    #1;
    check_eq("clk_second_half", {31'd0, bus.o_clk}, {31'd0, exp_clk(2 * m_pos + 1)});
    bus.i_load = 1'b0;
  endtask

  // Run with i_en=1 until the model sits at the given ratio and position.
  task automatic run_to(input int unsigned n, input int unsigned pos);
    int guard = 0;
    while (!(m_run && (m_n == n) && (m_pos == pos)) && (guard < 60)) begin
      cycle(1'b1, 1'b0, 0);
      guard++;
    end
    check_eq("reach_position", {31'd0, (m_run && (m_n == n) && (m_pos == pos))}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_en   = 1'b0;
    bus.i_load = 1'b0;
    bus.i_div  = '0;
    model_reset();

    // Reset values.
    #1;
    check_eq("rst_clk", {31'd0, bus.o_clk}, 32'd0);
    check_eq("rst_tick", {31'd0, bus.o_tick}, 32'd0);
    check_eq("rst_pending", {31'd0, bus.o_pending}, 32'd0);
    @(negedge i_clk);
    #1;
    i_rst = 1'b1;

    // Idle with i_en low: everything stays low.
    repeat (8) cycle(1'b0, 1'b0, 0);

    // Default ratio 4.
    repeat (12) cycle(1'b1, 1'b0, 0);

    // Odd ratio 5.
    cycle(1'b1, 1'b1, 5);
    repeat (20) cycle(1'b1, 1'b0, 0);

    // Running at 4, load 6 at cnt=1: pending until the boundary.
    cycle(1'b1, 1'b1, 4);
    run_to(4, 1);
    cycle(1'b1, 1'b1, 6);
    repeat (16) cycle(1'b1, 1'b0, 0);

    // Loads of 0 and 1 clamp to 2.
    cycle(1'b1, 1'b1, 0);
    repeat (8) cycle(1'b1, 1'b0, 0);
    cycle(1'b1, 1'b1, 1);
    repeat (8) cycle(1'b1, 1'b0, 0);

    // Load coinciding with a boundary: old pending applies, new one waits.
    cycle(1'b1, 1'b1, 3);
    run_to(3, 1);
    cycle(1'b1, 1'b1, 5);
    cycle(1'b1, 1'b1, 7);
    repeat (20) cycle(1'b1, 1'b0, 0);

    // Drop i_en at cnt=2 with N=6: period completes, then idle.
    cycle(1'b1, 1'b1, 6);
    run_to(6, 2);
    repeat (10) cycle(1'b0, 1'b0, 0);

    // Reset at cnt=3 with N=5: outputs clear immediately, clean restart.
    cycle(1'b1, 1'b1, 5);
    run_to(5, 3);
    i_rst = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_clk", {31'd0, bus.o_clk}, 32'd0);
    check_eq("midrst_tick", {31'd0, bus.o_tick}, 32'd0);
    check_eq("midrst_pending", {31'd0, bus.o_pending}, 32'd0);
    repeat (3) cycle(1'b1, 1'b1, 9);
    i_rst = 1'b1;
    repeat (12) cycle(1'b1, 1'b0, 0);

    // Random traffic.
    repeat (400) begin
      bit          en;
      bit          ld;
      int unsigned dv;
      en = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 7) == 0);
      dv = $urandom_range(0, 9);
      cycle(en, ld, dv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
